// File: rtl/stdp_update_sched.sv
// STDP update scheduler: pairs pre/post spike timers into per-synapse LTP/LTD requests
// and serves them round-robin through a shared weight port. Optional macro: STDP_EXP_DECAY_EN.
module stdp_update_sched #(
  parameter int WINDOW   = 16,
  parameter int LTP_STEP = 8,
  parameter int LTD_STEP = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [4:0] pre_spike,
  input  logic       post_spike,
  input  logic       learn_en,
  output logic [2:0] w_addr,
  output logic       w_rd,
  input  logic [7:0] w_rdata,
  output logic       w_wr,
  output logic [7:0] w_wdata,
  output logic       busy,
  output logic [4:0] ltp_pend,
  output logic [4:0] ltd_pend,
  output logic [7:0] dt_out,
  output logic [1:0] fsm_state
);

  // Weight port handshake: w_rd is high for exactly the RD cycle and w_rdata is
  // taken one cycle later (CALC); w_wr is high for exactly the WR cycle.
  typedef enum logic [1:0] {IDLE, RD, CALC, WR} state_t;

  localparam logic [8:0] LTP9 = 9'(LTP_STEP);
  localparam logic [8:0] LTD9 = 9'(LTD_STEP);

  state_t     state;
  logic [7:0] pre_t [5];
  logic [7:0] post_t;
  logic [7:0] ltp_dt [5];
  logic [7:0] ltd_dt [5];
  logic [2:0] rr;
  logic [2:0] idx;
  logic       serve_ltp;

  logic [4:0] ltp_req;
  logic [4:0] ltd_req;
  logic       sel_found;
  logic [2:0] sel_idx;
  logic [8:0] step;
  logic [8:0] sum;
  logic [8:0] diff;
  logic [7:0] new_w;

  always_comb begin
    ltp_req = '0;
    ltd_req = '0;
    for (int i = 0; i < 5; i++) begin
      // A same-cycle pre spike counts as dt=0 regardless of the stale timer value.
      ltp_req[i] = learn_en && post_spike && (pre_spike[i] || (int'(pre_t[i]) < WINDOW));
      ltd_req[i] = learn_en && pre_spike[i] && !post_spike && (int'(post_t) < WINDOW);
    end
  end

  always_comb begin
    sel_found = 1'b0;
    sel_idx   = '0;
    // Scan from the farthest candidate down so the nearest one to rr wins.
    for (int k = 4; k >= 0; k--) begin
      int j;
      j = int'(rr) + k;
      if (j >= 5) j = j - 5;
      if (ltp_pend[j] || ltd_pend[j]) begin
        sel_found = 1'b1;
        sel_idx   = 3'(j);
      end
    end
  end

  always_comb begin
    step = serve_ltp ? LTP9 : LTD9;
`ifdef STDP_EXP_DECAY_EN
    step = (dt_out >= 8'd32) ? 9'd0 : (step >> dt_out[4:2]);
`endif
    sum   = {1'b0, w_rdata} + step;
    diff  = {1'b0, w_rdata} - step;
    if (serve_ltp) new_w = sum[8] ? 8'd255 : sum[7:0];
    else           new_w = diff[8] ? 8'd0 : diff[7:0];
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      post_t    <= 8'd255;
      ltp_pend  <= '0;
      ltd_pend  <= '0;
      rr        <= '0;
      idx       <= '0;
      serve_ltp <= 1'b0;
      dt_out    <= '0;
      w_addr    <= '0;
      w_wdata   <= '0;
      w_rd      <= 1'b0;
      w_wr      <= 1'b0;
      for (int i = 0; i < 5; i++) begin
        pre_t[i]  <= 8'd255;
        ltp_dt[i] <= '0;
        ltd_dt[i] <= '0;
      end
    end else begin
      post_t <= post_spike ? 8'd0 : ((post_t == 8'd255) ? post_t : post_t + 8'd1);
      for (int i = 0; i < 5; i++)
        pre_t[i] <= pre_spike[i] ? 8'd0 : ((pre_t[i] == 8'd255) ? pre_t[i] : pre_t[i] + 8'd1);

      case (state)
        IDLE: begin
          if (sel_found) begin
            idx       <= sel_idx;
            serve_ltp <= ltp_pend[sel_idx];
            dt_out    <= ltp_pend[sel_idx] ? ltp_dt[sel_idx] : ltd_dt[sel_idx];
            w_addr    <= sel_idx;
            w_rd      <= 1'b1;
            state     <= RD;
          end
        end
        RD: begin
          w_rd  <= 1'b0;
          state <= CALC;
        end
        CALC: begin
          w_wdata <= new_w;
          w_wr    <= 1'b1;
          state   <= WR;
        end
        WR: begin
          w_wr   <= 1'b0;
          dt_out <= '0;
          rr     <= (idx == 3'd4) ? 3'd0 : idx + 3'd1;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase

      // Retire first, then set: a request landing on the retiring bit survives.
      for (int i = 0; i < 5; i++) begin
        if (state == WR && int'(idx) == i) begin
          if (serve_ltp) ltp_pend[i] <= 1'b0;
          else           ltd_pend[i] <= 1'b0;
        end
        if (ltp_req[i]) begin
          ltp_pend[i] <= 1'b1;
          ltp_dt[i]   <= pre_spike[i] ? 8'd0 : pre_t[i];
        end
        if (ltd_req[i]) begin
          ltd_pend[i] <= 1'b1;
          ltd_dt[i]   <= post_t;
        end
      end
    end
  end

  assign busy      = (state != IDLE);
  assign fsm_state = state;

endmodule

// File: tb/tb_stdp_update_sched.sv
// Bench for stdp_update_sched: directed scenarios plus random spikes, checked each cycle
// against a behavioural timer/pending/service model and a write scoreboard.
module tb_stdp_update_sched;

  localparam int WINDOW   = 16;
  localparam int LTP_STEP = 8;
  localparam int LTD_STEP = 4;

  logic       clk;
  logic       rst_n;
  logic [4:0] pre_spike;
  logic       post_spike;
  logic       learn_en;
  logic [2:0] w_addr;
  logic       w_rd;
  logic [7:0] w_rdata;
  logic       w_wr;
  logic [7:0] w_wdata;
  logic       busy;
  logic [4:0] ltp_pend;
  logic [4:0] ltd_pend;
  logic [7:0] dt_out;
  logic [1:0] fsm_state;

  stdp_update_sched #(.WINDOW(WINDOW), .LTP_STEP(LTP_STEP), .LTD_STEP(LTD_STEP)) dut (
    .clk(clk), .rst_n(rst_n), .pre_spike(pre_spike), .post_spike(post_spike),
    .learn_en(learn_en), .w_addr(w_addr), .w_rd(w_rd), .w_rdata(w_rdata),
    .w_wr(w_wr), .w_wdata(w_wdata), .busy(busy), .ltp_pend(ltp_pend),
    .ltd_pend(ltd_pend), .dt_out(dt_out), .fsm_state(fsm_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // weight memory seen by the DUT, and the reference model state
  logic [7:0] mem [5];
  int m_mem [5];
  int m_pt [5];
  int m_qt;
  bit m_lp [5];
  bit m_ld [5];
  int m_ldt [5];
  int m_ddt [5];
  int m_rr, m_svc, m_idx, m_dt;
  bit m_isltp;
  logic [10:0] exp_q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed=%0d expected=%0d at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [4:0] pack(input bit v [5]);
    logic [4:0] r;
    for (int i = 0; i < 5; i++) r[i] = v[i];
    return r;
  endfunction

  function automatic int new_weight(input int w, input bit ltp, input int dt);
    int st;
    st = ltp ? LTP_STEP : LTD_STEP;
`ifdef STDP_EXP_DECAY_EN
    st = (dt >= 32) ? 0 : (st >> (dt / 4));
`endif
    if (ltp) return (w + st > 255) ? 255 : w + st;
    return (w - st < 0) ? 0 : w - st;
  endfunction

  task automatic model_step(input logic [4:0] ps, input logic po, input logic le, input logic rn);
    bit lr [5];
    bit dr [5];
    int w;
    if (!rn) begin
      for (int i = 0; i < 5; i++) begin
        m_pt[i] = 255; m_lp[i] = 0; m_ld[i] = 0;
      end
      m_qt = 255; m_rr = 0; m_svc = 0; m_dt = 0; m_idx = 0;
      exp_q.delete();
      return;
    end
    for (int i = 0; i < 5; i++) begin
      lr[i] = le && po && (ps[i] || m_pt[i] < WINDOW);
      dr[i] = le && ps[i] && !po && (m_qt < WINDOW);
    end
    if (m_svc == 3) begin
      if (m_isltp) m_lp[m_idx] = 0; else m_ld[m_idx] = 0;
      m_rr = (m_idx + 1) % 5;
      m_svc = 0;
    end else if (m_svc == 2) begin
      w = new_weight(m_mem[m_idx], m_isltp, m_dt);
      m_mem[m_idx] = w;
      exp_q.push_back({3'(m_idx), 8'(w)});
      m_svc = 3;
    end else if (m_svc == 1) begin
      m_svc = 2;
    end else begin
      for (int k = 0; k < 5; k++) begin
        int j;
        j = (m_rr + k) % 5;
        if (m_svc == 0 && (m_lp[j] || m_ld[j])) begin
          m_idx = j; m_isltp = m_lp[j];
          m_dt = m_isltp ? m_ldt[j] : m_ddt[j];
          m_svc = 1;
        end
      end
    end
    for (int i = 0; i < 5; i++) begin
      if (lr[i]) begin m_lp[i] = 1; m_ldt[i] = ps[i] ? 0 : m_pt[i]; end
      if (dr[i]) begin m_ld[i] = 1; m_ddt[i] = m_qt; end
      m_pt[i] = ps[i] ? 0 : ((m_pt[i] < 255) ? m_pt[i] + 1 : 255);
    end
    m_qt = po ? 0 : ((m_qt < 255) ? m_qt + 1 : 255);
  endtask

  task automatic check_outputs(input logic rn);
    logic [10:0] e;
    chk("busy", 32'(busy), 32'(m_svc != 0));
    chk("fsm_state", 32'(fsm_state), 32'(m_svc));
    chk("ltp_pend", 32'(ltp_pend), 32'(pack(m_lp)));
    chk("ltd_pend", 32'(ltd_pend), 32'(pack(m_ld)));
    chk("dt_out", 32'(dt_out), 32'((m_svc != 0) ? m_dt : 0));
    chk("w_rd", 32'(w_rd), 32'(m_svc == 1));
    chk("w_wr", 32'(w_wr), 32'(m_svc == 3));
    chk("rd_wr_excl", 32'(w_rd & w_wr), 32'(0));
    if (!rn) begin
      chk("rst_addr", 32'(w_addr), 32'(0));
      chk("rst_wdata", 32'(w_wdata), 32'(0));
    end
    if (m_svc == 1) chk("rd_addr", 32'(w_addr), 32'(m_idx));
    if (w_wr) begin
      if (exp_q.size() == 0) chk("wr_unexpected", 32'(1), 32'(0));
      else begin
        e = exp_q.pop_front();
        chk("wr_addr", 32'(w_addr), 32'(e[10:8]));
        chk("wr_data", 32'(w_wdata), 32'(e[7:0]));
      end
    end
  endtask

  // driver: one clock cycle, entered and left at the falling edge
  task automatic tick(input logic [4:0] ps, input logic po, input logic le, input logic rn);
    logic rd_s, wr_s;
    logic [2:0] a_s;
    logic [7:0] d_s;
    pre_spike = ps; post_spike = po; learn_en = le; rst_n = rn;
    rd_s = w_rd; wr_s = w_wr; a_s = w_addr; d_s = w_wdata;
    model_step(ps, po, le, rn);
    @(posedge clk);
    #1;
    if (wr_s) mem[a_s] = d_s;
    w_rdata = rd_s ? mem[a_s] : 8'($urandom);
    @(negedge clk);
    check_outputs(rn);
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) tick(5'b0, 1'b0, 1'b1, 1'b1);
  endtask

  task automatic set_mem(input int i, input int v);
    mem[i] = 8'(v);
    m_mem[i] = v;
  endtask

  initial begin
    logic [4:0] ps;
    logic po, le, rn;
    logic [7:0] keep1;
    pre_spike = '0; post_spike = 1'b0; learn_en = 1'b1; rst_n = 1'b0; w_rdata = '0;
    for (int i = 0; i < 5; i++) begin
      set_mem(i, $urandom_range(0, 255));
      m_ldt[i] = 0; m_ddt[i] = 0;
    end
    m_isltp = 0;
    @(negedge clk);
    tick(5'b0, 1'b0, 1'b1, 1'b0);
    tick(5'b0, 1'b0, 1'b1, 1'b0);
    idle(20);

    // pre on synapse 2, post three cycles later -> potentiation by 8
    set_mem(2, 100);
    tick(5'b00100, 1'b0, 1'b1, 1'b1);
    idle(2);
    tick(5'b00000, 1'b1, 1'b1, 1'b1);
    chk("t1_pend", 32'(ltp_pend), 32'(5'b00100));
    idle(6);
    chk("t1_mem", 32'(mem[2]), 32'(108));
    idle(20);

    // post then pre on synapse 4 -> depression saturates at 0
    set_mem(4, 2);
    tick(5'b00000, 1'b1, 1'b1, 1'b1);
    idle(4);
    tick(5'b10000, 1'b0, 1'b1, 1'b1);
    idle(6);
    chk("t2_mem", 32'(mem[4]), 32'(0));
    idle(20);

    // all five synapses coincident with post -> five saturating writes
    for (int i = 0; i < 5; i++) set_mem(i, 250);
    tick(5'b11111, 1'b1, 1'b1, 1'b1);
    idle(21);
    for (int i = 0; i < 5; i++) chk("t3_mem", 32'(mem[i]), 32'(255));
    idle(20);

    // pairing outside the window -> nothing happens
    keep1 = mem[1];
    tick(5'b00010, 1'b0, 1'b1, 1'b1);
    idle(19);
    tick(5'b00000, 1'b1, 1'b1, 1'b1);
    chk("t4_busy", 32'(busy), 32'(0));
    idle(4);
    chk("t4_mem", 32'(mem[1]), 32'(keep1));
    idle(20);

    // reset while in CALC abandons the update
    keep1 = mem[3];
    tick(5'b01000, 1'b1, 1'b1, 1'b1);
    for (int k = 0; k < 8 && m_svc != 2; k++) idle(1);
    tick(5'b00000, 1'b0, 1'b1, 1'b0);
    chk("t5_busy", 32'(busy), 32'(0));
    tick(5'b00000, 1'b1, 1'b1, 1'b1);
    chk("t5_no_req", 32'(ltp_pend), 32'(0));
    idle(6);
    chk("t5_mem", 32'(mem[3]), 32'(keep1));
    idle(20);

    // learn_en low blocks a new pairing but not the pending update
    tick(5'b00001, 1'b1, 1'b1, 1'b1);
    tick(5'b00100, 1'b1, 1'b0, 1'b1);
    chk("t6_noset", 32'(ltp_pend[2]), 32'(0));
    idle(8);
    chk("t6_done", 32'(busy), 32'(0));

    // random spikes, occasional learn_en drop and reset outside the write cycle
    for (int n = 0; n < 1500; n++) begin
      for (int i = 0; i < 5; i++) ps[i] = ($urandom_range(0, 9) == 0);
      po = ($urandom_range(0, 7) == 0);
      le = ($urandom_range(0, 9) != 0);
      rn = !(($urandom_range(0, 299) == 0) && (m_svc != 3));
      tick(ps, po, le, rn);
    end
    idle(30);
    chk("exp_q_empty", 32'(exp_q.size()), 32'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
